// File: rtl/cnv_pkg.sv
// cnv_pkg: shared constants, tap indexing and FSM states for the 3x3 window generator
package cnv_pkg;
  localparam int PIX_W = 8;
  localparam int WIN_TAPS = 9;
  typedef enum logic [1:0] {ST_FILL, ST_RUN, ST_FLUSH} state_e;
  function automatic int tap_k(input int m, input int n);
    return 3 * (m + 1) + (n + 1);
  endfunction
endpackage

// File: rtl/line_buf.sv
// line_buf: DEPTH-deep circular delay line; reads the old word at addr while writing the new one
module line_buf #(
  parameter int DEPTH = 128,
  parameter int W = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          en,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  d,
  output logic [W-1:0]  q
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk) if (en) mem[addr] <= d;
  assign q = mem[addr];
endmodule

// File: rtl/win3x3_gen.sv
// win3x3_gen: streaming zero-padded 3x3 window generator with two line buffers and a self-timed flush
module win3x3_gen
  import cnv_pkg::state_e, cnv_pkg::ST_FILL, cnv_pkg::ST_RUN, cnv_pkg::ST_FLUSH, cnv_pkg::tap_k;
#(
  parameter int IMG_W = 128,
  parameter int IMG_H = 128,
  parameter int PIX_W = cnv_pkg::PIX_W,
  parameter int OUT_W = 128,
  localparam int ROW_W = $clog2(IMG_H),
  localparam int COL_W = $clog2(IMG_W)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             vld_i,
  input  logic [PIX_W-1:0] pix_i,
  output logic             rdy_o,
  output logic [OUT_W-1:0] win_o,
  output logic             vld_o,
  output logic [ROW_W-1:0] row_o,
  output logic [COL_W-1:0] col_o,
  output logic             eof_o
);
  localparam int PW = $clog2(IMG_W * IMG_H);
  state_e st_q, st_d;
  logic [PW-1:0] pos_q, pos_d;
  logic [COL_W-1:0] addr_q, addr_d, ccol_q, ccol_d, col_q, col_d;
  logic [ROW_W-1:0] crow_q, crow_d, row_q, row_d;
  logic [2:0][PIX_W-1:0] a_q, a_d, b_q, b_d, cur;
  logic [OUT_W-1:0] win_q, win_d;
  logic vld_q, vld_d, eof_q, eof_d;
  logic flush, adv, emit, last, keep;
  logic [PIX_W-1:0] x, mid, top, tap;
  line_buf #(.DEPTH(IMG_W), .W(PIX_W)) u_lb1 (.clk(clk), .en(adv), .addr(addr_q), .d(x), .q(mid));
  line_buf #(.DEPTH(IMG_W), .W(PIX_W)) u_lb2 (.clk(clk), .en(adv), .addr(addr_q), .d(mid), .q(top));
  // The newest column (x, mid, top) is the n=+1 tap of the window centred IMG_W+1 positions back
  always_comb begin
    flush = st_q == ST_FLUSH;
    adv = flush || vld_i;
    emit = adv && st_q != ST_FILL;
    last = flush && pos_q == PW'(IMG_W);
    x = flush ? '0 : pix_i;
    cur = {x, mid, top};
    a_d = adv ? cur : a_q;
    b_d = adv ? a_q : b_q;
    addr_d = adv ? (addr_q == COL_W'(IMG_W - 1) ? '0 : addr_q + 1'b1) : addr_q;
    st_d = st_q;
    pos_d = adv ? pos_q + 1'b1 : pos_q;
    if (st_q == ST_FILL && vld_i && pos_q == PW'(IMG_W)) st_d = ST_RUN;
    if (st_q == ST_RUN && vld_i && pos_q == PW'(IMG_W * IMG_H - 1)) begin
      st_d = ST_FLUSH;
      pos_d = '0;
    end
    if (last) begin
      st_d = ST_FILL;
      pos_d = '0;
    end
    ccol_d = emit ? (ccol_q == COL_W'(IMG_W - 1) ? '0 : ccol_q + 1'b1) : ccol_q;
    crow_d = emit && ccol_q == COL_W'(IMG_W - 1) ? (crow_q == ROW_W'(IMG_H - 1) ? '0 : crow_q + 1'b1) : crow_q;
    keep = 1'b0;
    tap = '0;
    win_d = emit ? '0 : win_q;
    // Padding comes only from the centre counters, so stale buffer words never leak out
    for (int m = 0; m < 3; m++)
      for (int n = 0; n < 3; n++) begin
        keep = emit && !(m == 0 && crow_q == '0) && !(m == 2 && crow_q == ROW_W'(IMG_H - 1))
               && !(n == 0 && ccol_q == '0) && !(n == 2 && ccol_q == COL_W'(IMG_W - 1));
        tap = n == 2 ? cur[m] : n == 1 ? a_q[m] : b_q[m];
        if (keep) win_d[PIX_W*tap_k(m - 1, n - 1) +: PIX_W] = tap;
      end
    vld_d = emit;
    eof_d = last;
    row_d = emit ? crow_q : row_q;
    col_d = emit ? ccol_q : col_q;
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      st_q <= ST_FILL;
      pos_q <= '0;
      addr_q <= '0;
      ccol_q <= '0;
      crow_q <= '0;
      a_q <= '0;
      b_q <= '0;
      win_q <= '0;
      vld_q <= 1'b0;
      eof_q <= 1'b0;
      row_q <= '0;
      col_q <= '0;
    end else begin
      st_q <= st_d;
      pos_q <= pos_d;
      addr_q <= addr_d;
      ccol_q <= ccol_d;
      crow_q <= crow_d;
      a_q <= a_d;
      b_q <= b_d;
      win_q <= win_d;
      vld_q <= vld_d;
      eof_q <= eof_d;
      row_q <= row_d;
      col_q <= col_d;
    end
  assign rdy_o = st_q != ST_FLUSH;
  assign win_o = win_q;
  assign vld_o = vld_q;
  assign row_o = row_q;
  assign col_o = col_q;
  assign eof_o = eof_q;
endmodule

// File: doc/win3x3_gen.md
Name: win3x3_gen

Overview:
Streaming 3x3 sliding-window generator. Accepts one pixel per cycle in raster order and emits, for every pixel position, the zero-padded 3x3 neighbourhood packed into the MAC `din` format. It replaces the behavioural window builder in the conv benches and feeds `mac` instances directly. It uses two on-chip line buffers and a self-timed end-of-frame flush, so the upstream source needs no knowledge of padding.

Parameters:
- IMG_W, 128: image width in pixels (>= 3)
- IMG_H, 128: image height in pixels (>= 2)
- PIX_W, 8: pixel width in bits
- OUT_W, 128: packed window width; must be >= 9*PIX_W, and bits above 9*PIX_W are always 0
- ROW_W, $clog2(IMG_H): row index width (localparam)
- COL_W, $clog2(IMG_W): column index width (localparam)

Ports:
- clk  input  1  system clock
- rstn  input  1  asynchronous active-low reset
- vld_i  input  1  input pixel valid
- pix_i  input  PIX_W  input pixel, raster order
- rdy_o  output  1  ready; a pixel is accepted on a cycle with vld_i && rdy_o
- win_o  output  OUT_W  packed 3x3 window
- vld_o  output  1  win_o valid; single-cycle qualifier
- row_o  output  ROW_W  centre row of the current window
- col_o  output  COL_W  centre column of the current window
- eof_o  output  1  high with vld_o on the last window of a frame

Behaviour:
- Clock and reset: clk single clock; rstn asynchronous assert, active low.
- Reset values: win_o=0, vld_o=0, row_o=0, col_o=0, eof_o=0, rdy_o=1. All counters and FSM state are cleared.
  - Line-buffer RAM is not cleared. Stale contents are masked by the padding logic.
- Packing: byte k = 3*(m+1)+(n+1) for m (row offset), n (col offset) in {-1,0,1}. win_o[PIX_W*k +: PIX_W] holds pixel(row+m, col+n), or 0 if that position is outside the image.
  - Byte 0 is top-left, byte 4 is centre, byte 8 is bottom-right.
- Stream positions: p = r*IMG_W + c, for 0..IMG_W*IMG_H-1.
  - The window for centre p is produced once position p+IMG_W+1 is available, whether accepted or flushed. This delay is uniform for all p, including the last column.
- Latency: vld_o for centre p rises 1 cycle after the cycle in which position p+IMG_W+1 is accepted or flushed. Output is registered.
- FSM:
  - FILL: accept pixels while positions 0..IMG_W are entered; no output. Go to RUN after position IMG_W is accepted.
  - RUN: each accepted pixel produces exactly one window. Go to FLUSH after position IMG_W*IMG_H-1 is accepted.
  - FLUSH: rdy_o=0. Insert exactly IMG_W+1 zero pixels, one per cycle regardless of vld_i, each producing one window. On the last flush cycle, eof_o=1 on the following output and the FSM returns to FILL with rdy_o=1.
- Bubbles: vld_i low in FILL or RUN means no state advance and vld_o=0 next cycle.
- Output count: exactly IMG_W*IMG_H windows per frame, in raster order. row_o and col_o increment with wrap at IMG_W-1.
- Padding: computed from the centre row/col counters, never from buffer contents.
  - Row 0 masks m=-1; row IMG_H-1 masks m=+1.
  - Column 0 masks n=-1; column IMG_W-1 masks n=+1.
- Frame boundary: the first pixel accepted after FLUSH is position 0 of a new frame. No data from the previous frame may appear in any window.
- Reset mid-frame: all output stops on the next edge and the partial frame is discarded. The next accepted pixel is position 0.
- Width rule: pixels are passed through untouched; no arithmetic is performed on data.

Decomposition:
- Shared package cnv_pkg holds:
  - PIX_W and WIN_TAPS=9 constants
  - a tap-index function k(m,n)
  - the FSM state enum (ST_FILL, ST_RUN, ST_FLUSH)
- Sub-module line_buf: single-port-read/write, IMG_W-deep, PIX_W-wide circular delay line with a shared address counter. Instantiated twice.
- The 3x3 tap register array and the padding mask live in the top module.

Test Plan:
1. IMG_W=4, IMG_H=4, pixels 1..16 streamed with vld_i held high.
   - First vld_o occurs 1 cycle after the 6th acceptance, with bytes 0..8 = 0,0,0,0,1,2,0,5,6 and row/col = 0/0.
   - 16 windows in total. The last window is bytes 11,12,0,15,16,0,0,0,0 with eof_o=1.
2. Same frame, checking flush timing: rdy_o is low for exactly 5 cycles after pixel 16 is accepted, vld_o is high on each of those 5 windows, and rdy_o returns to 1 afterwards.
3. Same frame with random vld_i gaps (about 40% idle): window sequence identical to scenario 1, and no vld_o on bubble cycles.
4. Two 4x4 frames back to back (values 1..16, then 101..116): frame-2 window (0,0) = 0,0,0,0,101,102,0,105,106. No byte from frame 1 appears in frame 2.
5. rstn pulsed low after 9 pixels: all outputs are 0 and rdy_o=1 during reset. The next full frame reproduces scenario 1 exactly.
6. Defaults, 128x128 butterfly_08bit.hex: all 16384 win_o values match a software zero-padded 3x3 golden model. Four `mac` instances are driven with the existing filters, and their acc_o outputs match the golden model.
